// File: rtl/ysyx_25060170_fetch_unit_if.sv
// Fetch unit bus: imem request/response channel plus the instruction channel to the IDU.
// Latency: none (wires only).
// Backpressure: req_ready and out_ready are the only stall inputs; responses are never stalled.
interface ysyx_25060170_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_err;

    modport master (
        output req_valid, req_addr, out_valid, out_pc, out_inst, out_err,
        input  req_ready, rsp_valid, rsp_data, rsp_err, out_ready
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_pc, out_inst, out_err,
        output req_ready, rsp_valid, rsp_data, rsp_err, out_ready
    );
endinterface

// File: rtl/ysyx_25060170_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, stale-response dropping, fetch queue to IDU. Optional YSYX_25060170_FETCH_BYPASS_EN.
// Latency: response to out_valid 1 cycle (0 with YSYX_25060170_FETCH_BYPASS_EN when queue empty); redirect to new request 1 cycle.
// Backpressure: requests stop when outstanding + queued reaches FQ_DEPTH, so responses always have a queue slot.

module ysyx_25060170_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_vld,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop_vld);
        end
    end

    // Storage is not reset; consumers qualify head_dat with count.
    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ysyx_25060170_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         jump_en,
    input  logic [XLEN-1:0]              jump_addr,
    ysyx_25060170_fetch_unit_if.master   bus
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            err;
    } fq_entry_t;

    logic [XLEN-1:0] pc;
    logic            run;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   qcount;
    logic [CW:0]     used;
    logic [XLEN-1:0] if_head;
    fq_entry_t       fq_head;
    fq_entry_t       fq_in;
    logic            req_fire;
    logic            rsp_keep;
    logic            fq_empty;
    logic            fq_push;
    logic            fq_pop;
    logic            byp;

    assign used     = {1'b0, inflight} + {1'b0, qcount};
    assign fq_empty = (qcount == '0);
    assign rsp_keep = bus.rsp_valid && (drop_cnt == '0);

    // run holds off the first request until one edge after reset release.
    assign bus.req_valid = run && (used < (CW+1)'(FQ_DEPTH)) && !jump_en;
    assign bus.req_addr  = pc;
    assign req_fire      = bus.req_valid && bus.req_ready;

`ifdef YSYX_25060170_FETCH_BYPASS_EN
    assign byp = rsp_keep && fq_empty && (inflight != '0);
`else
    assign byp = 1'b0;
`endif

    assign fq_in   = '{pc: if_head, inst: bus.rsp_data, err: bus.rsp_err};
    assign fq_push = rsp_keep && !jump_en && !(byp && bus.out_ready);
    assign fq_pop  = !fq_empty && bus.out_ready && !jump_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            run      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (jump_en) begin
                pc       <= jump_addr;
                // Everything still outstanding after this cycle belongs to the old path.
                drop_cnt <= inflight - CW'(bus.rsp_valid);
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (bus.rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    ysyx_25060170_fifo #(.W(XLEN), .DEPTH(FQ_DEPTH), .CW(CW)) u_inflight (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push_vld (req_fire),
        .push_dat (pc),
        .pop_vld  (bus.rsp_valid),
        .head_dat (if_head),
        .count    (inflight)
    );

    ysyx_25060170_fifo #(.W($bits(fq_entry_t)), .DEPTH(FQ_DEPTH), .CW(CW)) u_fetch_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (jump_en),
        .push_vld (fq_push),
        .push_dat (fq_in),
        .pop_vld  (fq_pop),
        .head_dat (fq_head),
        .count    (qcount)
    );

    assign bus.out_valid = !fq_empty || byp;
    assign bus.out_pc    = !fq_empty ? fq_head.pc   : (byp ? if_head      : '0);
    assign bus.out_inst  = !fq_empty ? fq_head.inst : (byp ? bus.rsp_data : '0);
    assign bus.out_err   = !fq_empty ? fq_head.err  : (byp && bus.rsp_err);
endmodule

// File: tb/tb_ysyx_25060170_fetch_unit.sv
// Self-checking bench for ysyx_25060170_fetch_unit: in-order memory model, stream-level reference, directed tables.
module tb_ysyx_25060170_fetch_unit;
    localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef YSYX_25060170_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;

    ysyx_25060170_fetch_unit_if #(.XLEN(32)) bus ();

    ysyx_25060170_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FQ_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: requested/delivered addresses run sequentially from the last reset/redirect target.
    logic [31:0] pending[$];
    int          q_cnt, stale_cnt;
    logic [31:0] exp_fetch, exp_out;
    int          k_req, k_rsp, k_out;
    bit          jmp_req;
    logic [31:0] jmp_tgt;
    bit          last_req_fire, last_out_fire, last_out_err;
    logic [31:0] last_req_addr, last_out_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a == 32'h8000_0008) || (a[6:2] == 5'd19);
    endfunction

    function automatic bit rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic model_reset();
        pending.delete();
        q_cnt = 0;
        stale_cnt = 0;
        exp_fetch = RPC;
        exp_out = RPC;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        jump_en = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.req_valid), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_out_inst", bus.out_inst, 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step();
        bit          rsp_now, exp_rv, byp, exp_ov, fire_out;
        logic [31:0] rsp_pc;
        @(posedge clk);
        #1;
        jump_en = jmp_req;
        jump_addr = jmp_req ? jmp_tgt : $urandom;
        jmp_req = 1'b0;
        bus.req_ready = rnd(k_req);
        bus.out_ready = rnd(k_out);
        rsp_now = (pending.size() > 0) && rnd(k_rsp);
        rsp_pc = rsp_now ? pending[0] : 32'h0;
        bus.rsp_valid = rsp_now;
        bus.rsp_data = rsp_now ? inst_of(rsp_pc) : $urandom;
        bus.rsp_err = rsp_now ? err_of(rsp_pc) : 1'b0;
        #1;
        exp_rv = (pending.size() + q_cnt < 4) && !jump_en;
        chk("req_valid", 32'(bus.req_valid), 32'(exp_rv));
        byp = BYP && rsp_now && (stale_cnt == 0) && (q_cnt == 0);
        exp_ov = (q_cnt > 0) || byp;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) chk("out_pc", bus.out_pc, exp_out);
        fire_out = exp_ov && bus.out_ready && !jump_en;
        last_out_fire = fire_out;
        last_out_pc = bus.out_pc;
        last_out_err = bus.out_err;
        if (fire_out) begin
            chk("out_inst", bus.out_inst, inst_of(exp_out));
            chk("out_err", 32'(bus.out_err), 32'(err_of(exp_out)));
        end
        last_req_fire = exp_rv && bus.req_ready;
        last_req_addr = bus.req_addr;
        if (jump_en) begin
            if (rsp_now) void'(pending.pop_front());
            stale_cnt = pending.size();
            q_cnt = 0;
            exp_fetch = jump_addr;
            exp_out = jump_addr;
        end else begin
            if (rsp_now) begin
                void'(pending.pop_front());
                if (stale_cnt > 0) stale_cnt--;
                else q_cnt++;
            end
            if (fire_out) begin
                exp_out += 32'd4;
                q_cnt--;
            end
            if (last_req_fire) begin
                chk("req_addr", bus.req_addr, exp_fetch);
                pending.push_back(exp_fetch);
                exp_fetch += 32'd4;
            end
        end
    endtask

    typedef struct {
        logic [31:0] jaddr;
        logic [31:0] a0, a1, a2;
    } jvec_t;

    jvec_t jtab[5];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, bad;
        bit          seen8, err8, seenc, errc, got;
        logic [31:0] reqs[$];
        logic [31:0] outs[$];

        jtab[0] = '{32'h8000_1000, 32'h8000_1000, 32'h8000_1004, 32'h8000_1008};
        jtab[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        jtab[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        jtab[3] = '{32'h0000_0102, 32'h0000_0102, 32'h0000_0106, 32'h0000_010A};
        jtab[4] = '{32'h4000_0040, 32'h4000_0040, 32'h4000_0044, 32'h4000_0048};
        jmp_req = 1'b0;
        jmp_tgt = '0;
        bus.rsp_data = '0;
        bus.rsp_err = 1'b0;

        // Streaming with a 1-cycle memory and an always-ready IDU.
        do_reset();
        k_req = 100; k_rsp = 100; k_out = 100;
        n = 0; seen8 = 0; err8 = 0; seenc = 0; errc = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (last_req_fire) reqs.push_back(last_req_addr);
            if (i >= 5 && last_out_fire) n++;
            if (last_out_fire && last_out_pc == 32'h8000_0008) begin seen8 = 1; err8 = last_out_err; end
            if (last_out_fire && last_out_pc == 32'h8000_000C) begin seenc = 1; errc = last_out_err; end
        end
        chk("first_req", reqs[0], 32'h8000_0000);
        chk("second_req", reqs[1], 32'h8000_0004);
        chk("third_req", reqs[2], 32'h8000_0008);
        chk("throughput", n, 12);
        chk("err_at_8", {30'd0, seen8, err8}, 32'd3);
        chk("noerr_at_c", {30'd0, seenc, errc}, 32'd2);

        // IDU stalled: exactly four requests, then drain in order.
        do_reset();
        k_out = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_req_fire) n++;
        end
        chk("stall_req_count", n, 4);
        chk("stall_req_valid", 32'(bus.req_valid), 0);
        k_out = 100;
        n = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_out_fire) n++;
            if (last_req_fire) bad++;
        end
        chk("drain_out_count", 32'(n >= 8), 1);
        chk("resume_requests", 32'(bad > 0), 1);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) step();
        do_reset();
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (last_req_fire) begin
                got = 1;
                chk("restart_addr", last_req_addr, RPC);
            end
        end
        chk("restart_seen", 32'(got), 1);

        // Redirect with three requests outstanding and memory silent.
        do_reset();
        k_rsp = 0;
        for (int i = 0; i < 10 && pending.size() < 3; i++) step();
        chk("outstanding_before_jump", pending.size(), 3);
        jmp_req = 1; jmp_tgt = 32'h8000_1000;
        step();
        k_rsp = 100;
        got = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_out_fire && !got) begin
                got = 1;
                chk("first_pc_after_jump", last_out_pc, 32'h8000_1000);
            end
            if (last_out_fire && last_out_pc < 32'h8000_1000) bad++;
        end
        chk("jump_out_seen", 32'(got), 1);
        chk("stale_delivered", bad, 0);

        // Redirect table, including wrap past the top of the address space.
        foreach (jtab[t]) begin
            k_req = 100; k_rsp = 70; k_out = 100;
            for (int i = 0; i < 3; i++) step();
            jmp_req = 1; jmp_tgt = jtab[t].jaddr;
            step();
            reqs.delete(); outs.delete();
            for (int i = 0; i < 30 && (reqs.size() < 3 || outs.size() < 3); i++) begin
                step();
                if (last_req_fire) reqs.push_back(last_req_addr);
                if (last_out_fire) outs.push_back(last_out_pc);
            end
            if (reqs.size() < 3 || outs.size() < 3) begin
                chk("jtab_timeout", reqs.size() + outs.size(), 6);
            end else begin
                chk("jtab_req0", reqs[0], jtab[t].a0);
                chk("jtab_req1", reqs[1], jtab[t].a1);
                chk("jtab_req2", reqs[2], jtab[t].a2);
                chk("jtab_out0", outs[0], jtab[t].a0);
                chk("jtab_out2", outs[2], jtab[t].a2);
            end
        end

        // Random traffic with random redirects.
        for (int ph = 0; ph < 20; ph++) begin
            k_req = $urandom_range(20, 100);
            k_rsp = $urandom_range(20, 100);
            k_out = $urandom_range(10, 100);
            for (int i = 0; i < 200; i++) begin
                if (rnd(3)) begin
                    jmp_req = 1;
                    case ($urandom_range(2))
                        0: jmp_tgt = 32'hFFFF_FFF0;
                        1: jmp_tgt = RPC;
                        default: jmp_tgt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
                    endcase
                end
                step();
            end
            if (ph == 10) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
